// File: rtl/target_spawner.sv
// Target spawner for a ten-target reaction game. Picks a lit target from the random index,
// times its lifetime, judges button hits, and keeps the score (never 0) and miss counters.
module target_spawner #(
    parameter int unsigned LIFETIME  = 50_000_000,
    parameter int unsigned GAP       = 12_500_000,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  ranNumTen,
    input  logic [9:0]  hit,
    output logic [9:0]  target,
    output logic        spawn_pulse,
    output logic [31:0] score,
    output logic [15:0] misses
);

    localparam int LIFE_W  = $clog2(LIFETIME + 1);
    localparam int GAP_W   = $clog2(GAP + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PICK,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t             state, state_next;
    logic [9:0]         target_next;
    logic               spawn_next;
    logic [31:0]        score_next;
    logic [15:0]        misses_next;
    logic [3:0]         prev_idx, prev_next;
    logic [RETRY_W-1:0] retry, retry_next;
    logic [LIFE_W-1:0]  life, life_next;
    logic [GAP_W-1:0]   gap, gap_next;
    logic [9:0]         hit_q;

    logic [9:0] hit_rise;
    logic       sample_valid;
    logic       retry_exhausted;
    logic [3:0] fallback_idx;
    logic [3:0] pick_idx;
    logic [31:0] score_inc;
    logic [15:0] misses_inc;

    assign hit_rise        = hit & ~hit_q;
    assign sample_valid    = (ranNumTen <= 4'd9) && (ranNumTen != prev_idx);
    assign retry_exhausted = (retry == RETRY_W'(MAX_RETRY - 1));
    // prev_idx is 0-9 or 4'hF ("none"); both 9 and F wrap to target 0.
    assign fallback_idx    = (prev_idx >= 4'd9) ? 4'd0 : prev_idx + 4'd1;
    assign pick_idx        = sample_valid ? ranNumTen : fallback_idx;
    assign score_inc       = (score == 32'hFFFF_FFFF) ? score : score + 32'd1;
    assign misses_inc      = (misses == 16'hFFFF) ? misses : misses + 16'd1;

    always_comb begin
        // NOTE: every next-value is defaulted first so no path leaves a latch behind.
        state_next  = state;
        target_next = target;
        spawn_next  = 1'b0;
        score_next  = score;
        misses_next = misses;
        prev_next   = prev_idx;
        retry_next  = retry;
        life_next   = life;
        gap_next    = gap;

        if (!enable) begin
            state_next  = S_IDLE;
            target_next = '0;
            retry_next  = '0;
            life_next   = '0;
            gap_next    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    target_next = '0;
                    state_next  = S_PICK;
                end
                S_PICK: begin
                    if (sample_valid || retry_exhausted) begin
                        target_next = 10'd1 << pick_idx;
                        prev_next   = pick_idx;
                        spawn_next  = 1'b1;
                        life_next   = '0;
                        retry_next  = '0;
                        state_next  = S_ACTIVE;
                    end else begin
                        retry_next = retry + RETRY_W'(1);
                    end
                end
                S_ACTIVE: begin
                    life_next = life + LIFE_W'(1);
                    // A hit edge on the final lifetime cycle wins over the timeout.
                    if (hit_rise != '0) begin
                        if (hit_rise == target) score_next = score_inc;
                        else                    misses_next = misses_inc;
                        target_next = '0;
                        gap_next    = '0;
                        state_next  = S_GAP;
                    end else if (life == LIFE_W'(LIFETIME - 1)) begin
                        misses_next = misses_inc;
                        target_next = '0;
                        gap_next    = '0;
                        state_next  = S_GAP;
                    end
                end
                S_GAP: begin
                    target_next = '0;
                    if (gap == GAP_W'(GAP - 1)) state_next = S_PICK;
                    else                        gap_next   = gap + GAP_W'(1);
                end
                default: begin
                    state_next  = S_IDLE;
                    target_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            target      <= '0;
            spawn_pulse <= 1'b0;
            score       <= 32'd1;
            misses      <= '0;
            prev_idx    <= 4'hF;
            retry       <= '0;
            life        <= '0;
            gap         <= '0;
            hit_q       <= '0;
        end else begin
            state       <= state_next;
            target      <= target_next;
            spawn_pulse <= spawn_next;
            score       <= score_next;
            misses      <= misses_next;
            prev_idx    <= prev_next;
            retry       <= retry_next;
            life        <= life_next;
            gap         <= gap_next;
            hit_q       <= hit;
        end
    end

endmodule

// File: tb/tb_target_spawner.sv
// Bench for target_spawner: table of pick scenarios plus hand-written hit/timeout/enable/reset
// sequences; spawned targets are checked against a queue of expected targets.
module tb_target_spawner;

    localparam int LIFETIME  = 8;
    localparam int GAP       = 4;
    localparam int MAX_RETRY = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  ran;
    logic [9:0]  hit;
    logic [9:0]  target;
    logic        spawn_pulse;
    logic [31:0] score;
    logic [15:0] misses;

    int errors = 0;
    int checks = 0;
    logic [9:0]  exp_q[$];
    logic [31:0] exp_score;
    logic [15:0] exp_misses;

    typedef struct {
        logic [3:0] ran_a;
        logic [3:0] ran_b;
        logic [9:0] exp_tgt;
        int         samples;
    } pick_vec_t;

    pick_vec_t vecs[9];

    target_spawner #(
        .LIFETIME (LIFETIME),
        .GAP      (GAP),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .ranNumTen  (ran),
        .hit        (hit),
        .target     (target),
        .spawn_pulse(spawn_pulse),
        .score      (score),
        .misses     (misses)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every spawn pulse pops the next expected target.
    always @(negedge clock) begin
        logic [9:0] e;
        if (!reset && spawn_pulse) begin
            if (exp_q.size() == 0) begin
                check("spawn_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("spawn_target", {22'd0, target}, {22'd0, e});
                check("spawn_onehot", 32'($onehot(target)), 32'd1);
            end
        end
    end

    task automatic wait_spawn(input int exp_ticks, input logic [3:0] ran_b, input int switch_at,
                              input string name);
        int n;
        for (n = 1; n <= 40; n++) begin
            tick();
            if (spawn_pulse) break;
            if (n == switch_at) ran = ran_b;
        end
        check(name, n, exp_ticks);
    endtask

    task automatic run_timeout(input logic [9:0] exp_tgt);
        repeat (LIFETIME - 1) tick();
        check("lit_before_timeout", {22'd0, target}, {22'd0, exp_tgt});
        tick();
        exp_misses++;
        check("timeout_target", {22'd0, target}, 32'd0);
        check("timeout_misses", {16'd0, misses}, {16'd0, exp_misses});
        check("timeout_score", score, exp_score);
    endtask

    task automatic check_counts(input string name);
        check({name, "_score"}, score, exp_score);
        check({name, "_misses"}, {16'd0, misses}, {16'd0, exp_misses});
    endtask

    initial begin
        vecs[0] = '{4'd3,  4'd3,  10'h008, 1};
        vecs[1] = '{4'd3,  4'd12, 10'h010, MAX_RETRY};
        vecs[2] = '{4'd12, 4'd12, 10'h020, MAX_RETRY};
        vecs[3] = '{4'd9,  4'd9,  10'h200, 1};
        vecs[4] = '{4'd9,  4'd9,  10'h001, MAX_RETRY};
        vecs[5] = '{4'd11, 4'd6,  10'h040, 3};
        vecs[6] = '{4'd14, 4'd14, 10'h080, MAX_RETRY};
        vecs[7] = '{4'd0,  4'd0,  10'h001, 1};
        vecs[8] = '{4'd2,  4'd7,  10'h004, 1};

        reset = 1'b1; enable = 1'b0; ran = 4'd0; hit = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        exp_score = 32'd1; exp_misses = 16'd0;
        check("reset_target", {22'd0, target}, 32'd0);
        check("reset_spawn", {31'd0, spawn_pulse}, 32'd0);
        check_counts("reset");

        // Two-cycle latency from enable, single-cycle spawn pulse.
        ran = 4'd3; enable = 1'b1; exp_q.push_back(10'h008);
        tick();
        check("latency_c1_target", {22'd0, target}, 32'd0);
        tick();
        check("latency_c2_target", {22'd0, target}, 32'h008);
        check("latency_c2_spawn", {31'd0, spawn_pulse}, 32'd1);
        tick();
        check("spawn_one_cycle", {31'd0, spawn_pulse}, 32'd0);
        tick();
        hit = 10'h008;
        tick();
        exp_score = 32'd2;
        check("hit_target_clear", {22'd0, target}, 32'd0);
        check_counts("hit");
        hit = '0; ran = 4'd5; exp_q.push_back(10'h020);
        wait_spawn(GAP + 1, 4'd5, 99, "gap_to_spawn");
        run_timeout(10'h020);

        // Pick table: each entry spawns and then times out.
        for (int i = 0; i < 9; i++) begin
            ran = vecs[i].ran_a;
            exp_q.push_back(vecs[i].exp_tgt);
            wait_spawn(GAP + vecs[i].samples, vecs[i].ran_b, GAP + 2, "pick_latency");
            run_timeout(vecs[i].exp_tgt);
        end

        // Wrong/extra button.
        ran = 4'd3; exp_q.push_back(10'h008);
        wait_spawn(GAP + 1, 4'd3, 99, "wrong_spawn");
        hit = 10'h018;
        tick();
        exp_misses++;
        check("wrong_target", {22'd0, target}, 32'd0);
        check_counts("wrong");
        hit = '0;

        // Button held across spawn, then a hit edge on the timeout cycle.
        hit = 10'h010; ran = 4'd4; exp_q.push_back(10'h010);
        wait_spawn(GAP + 1, 4'd4, 99, "held_spawn");
        repeat (3) tick();
        check("held_target", {22'd0, target}, 32'h010);
        check_counts("held");
        hit = '0;
        repeat (LIFETIME - 4) tick();
        check("late_target", {22'd0, target}, 32'h010);
        hit = 10'h010;
        tick();
        exp_score++;
        check("late_hit_target", {22'd0, target}, 32'd0);
        check_counts("late_hit");
        hit = '0;

        // Disable mid-ACTIVE.
        ran = 4'd6; exp_q.push_back(10'h040);
        wait_spawn(GAP + 1, 4'd6, 99, "dis_spawn");
        repeat (2) tick();
        enable = 1'b0;
        tick();
        check("dis_target", {22'd0, target}, 32'd0);
        check("dis_spawn_low", {31'd0, spawn_pulse}, 32'd0);
        check_counts("dis");
        repeat (3) tick();
        check("dis_idle_target", {22'd0, target}, 32'd0);
        enable = 1'b1; ran = 4'd7; exp_q.push_back(10'h080);
        tick();
        check("reen_c1_target", {22'd0, target}, 32'd0);
        tick();
        check("reen_c2_target", {22'd0, target}, 32'h080);

        // Reset mid-ACTIVE with enable held high; prev_idx returns to "none".
        tick();
        reset = 1'b1;
        tick();
        exp_score = 32'd1; exp_misses = 16'd0;
        check("rst_target", {22'd0, target}, 32'd0);
        check_counts("rst");
        reset = 1'b0; ran = 4'd12; exp_q.push_back(10'h001);
        wait_spawn(1 + MAX_RETRY, 4'd12, 99, "rst_fallback");

        // Score saturation.
        tick();
        hit = 10'h001;
        tick();
        exp_score = 32'd2;
        check_counts("pre_sat");
        hit = '0; ran = 4'd8; exp_q.push_back(10'h100);
        force dut.score = 32'hFFFF_FFFF;
        tick();
        release dut.score;
        exp_score = 32'hFFFF_FFFF;
        check("sat_preload", score, exp_score);
        wait_spawn(GAP, 4'd8, 99, "sat_spawn");
        hit = 10'h100;
        tick();
        check("sat_target", {22'd0, target}, 32'd0);
        check_counts("sat");
        hit = '0;
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
